// File: rtl/alu_ctrl.sv
// Operand/opcode entry sequencer for the lab-board 8-op ALU: button-driven loads, opcode check, result display.
// Optional build macro ALU_CTRL_DEBOUNCE_EN adds a per-button synchronizer and debounce filter.
module alu_ctrl #(
  parameter int unsigned N         = 8,
  parameter int unsigned N_OP      = 6,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    sw,
  input  logic            btn_a,
  input  logic            btn_b,
  input  logic            btn_op,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [N_OP-1:0] alu_op,
  input  logic [N-1:0]    alu_result,
  output logic [N-1:0]    leds,
  output logic [1:0]      state,
  output logic            op_err
);

  if (N_OP > N || DB_CYCLES == 0) begin : g_param_chk
    $error("alu_ctrl: need N_OP <= N and DB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  localparam int unsigned BTN_A  = 0;
  localparam int unsigned BTN_B  = 1;
  localparam int unsigned BTN_OP = 2;

  logic [2:0] w_btn_raw;
  logic [2:0] w_level;
  logic [2:0] r_hist;
  logic [2:0] w_pulse;

  assign w_btn_raw = {btn_op, btn_b, btn_a};

`ifdef ALU_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_filt;
  logic [CNT_W-1:0] r_cnt [3];

  // Filtered level follows the synchronized level only after DB_CYCLES stable samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_filt  <= '1;
      r_hist  <= '1;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_hist  <= r_filt;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
            r_filt[i] <= r_sync2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_level = r_filt;
`else
  // History resets high so a button held through reset never produces a pulse.
  always_ff @(posedge clk) begin
    if (reset) r_hist <= '1;
    else       r_hist <= w_btn_raw;
  end

  assign w_level = w_btn_raw;
`endif

  assign w_pulse = w_level & ~r_hist;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_a, w_a_nxt;
  logic [N-1:0]    r_b, w_b_nxt;
  logic [N_OP-1:0] r_op, w_op_nxt;
  logic [N-1:0]    r_leds, w_leds_nxt;
  logic            r_err, w_err_nxt;
  logic [N_OP-1:0] w_sw_op;
  logic            w_op_valid;

  assign w_sw_op = sw[N_OP-1:0];

  // Opcodes implemented by the ALU.
  always_comb begin
    w_op_valid = 1'b0;
    case (w_sw_op)
      N_OP'(32), N_OP'(34), N_OP'(36), N_OP'(37),
      N_OP'(38), N_OP'(3),  N_OP'(2),  N_OP'(39): w_op_valid = 1'b1;
      default: w_op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_leds  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_leds  <= w_leds_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Only the button expected in the current state has any effect.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_leds_nxt  = r_leds;
    w_err_nxt   = r_err;
    case (r_state)
      WAIT_A: begin
        if (w_pulse[BTN_A]) begin
          w_a_nxt     = sw;
          w_state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (w_pulse[BTN_B]) begin
          w_b_nxt     = sw;
          w_state_nxt = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (w_pulse[BTN_OP]) begin
          if (w_op_valid) begin
            w_op_nxt    = w_sw_op;
            w_err_nxt   = 1'b0;
            w_state_nxt = SHOW;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      SHOW: begin
        w_leds_nxt = alu_result;
        if (w_pulse[BTN_A]) begin
          w_a_nxt     = sw;
          w_state_nxt = WAIT_B;
        end
      end
      default: w_state_nxt = WAIT_A;
    endcase
  end

  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign alu_op = r_op;
  assign leds   = r_leds;
  assign state  = r_state;
  assign op_err = r_err;

endmodule
